// File: rtl/fir_tcdm_arbiter.sv
// Shares one TCDM master port between NR streamers with in-order response routing.
// Define FIR_TCDM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fir_tcdm_arbiter #(
  parameter int NR      = 3,
  parameter int DW      = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic [NR-1:0]                 in_req,
  output logic [NR-1:0]                 in_gnt,
  input  logic [NR-1:0][31:0]           in_add,
  input  logic [NR-1:0]                 in_wen,
  input  logic [NR-1:0][DW/8-1:0]       in_be,
  input  logic [NR-1:0][DW-1:0]         in_data,
  output logic [NR-1:0][DW-1:0]         in_r_data,
  output logic [NR-1:0]                 in_r_valid,
  output logic                          out_req,
  output logic [31:0]                   out_add,
  output logic                          out_wen,
  output logic [DW/8-1:0]               out_be,
  output logic [DW-1:0]                 out_data,
  input  logic                          out_gnt,
  input  logic [DW-1:0]                 out_r_data,
  input  logic                          out_r_valid,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding_o,
  output logic                          err_o
);

  localparam int IW = $clog2(NR);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);

  logic [IW-1:0] r_fifo [MAX_OUT];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic          w_clr;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_hs;
  logic          w_pop;
  logic          w_unexp;
  logic [IW-1:0] w_sel;
  logic [IW-1:0] w_head;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // A clear cycle behaves combinationally as if the FIFO were already empty.
  assign w_clr   = rst_i | clear_i;
  assign w_count = w_clr ? '0 : r_count;
  assign w_full  = (w_count == CW'(MAX_OUT));
  assign out_req = (|in_req) & ~w_full;
  assign w_hs    = out_req & out_gnt;
  assign w_pop   = out_r_valid & (w_count != '0);
  assign w_unexp = out_r_valid & (w_count == '0);
  assign w_head  = r_fifo[r_rptr];

`ifdef FIR_TCDM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_sel = '0;
    for (int i = NR - 1; i >= 0; i--) begin
      if (in_req[i]) w_sel = IW'(i);
    end
  end
`else
  logic [IW-1:0] r_rr_ptr;

  // Scan from farthest to nearest so the request closest after the pointer wins.
  always_comb begin
    int            idx;
    logic [IW-1:0] w_idx;
    idx   = 0;
    w_idx = '0;
    w_sel = '0;
    for (int i = NR; i >= 1; i--) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NR) idx = idx - NR;
      w_idx = IW'(idx);
      if (in_req[w_idx]) w_sel = w_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_clr)     r_rr_ptr <= IW'(NR - 1);
    else if (w_hs) r_rr_ptr <= w_sel;
  end
`endif

  always_comb begin
    in_gnt   = '0;
    out_add  = '0;
    out_wen  = 1'b0;
    out_be   = '0;
    out_data = '0;
    if (out_req) begin
      out_add  = in_add[w_sel];
      out_wen  = in_wen[w_sel];
      out_be   = in_be[w_sel];
      out_data = in_data[w_sel];
    end
    if (w_hs) in_gnt[w_sel] = 1'b1;
  end

  always_comb begin
    in_r_data  = '0;
    in_r_valid = '0;
    if (w_count != '0) begin
      in_r_data[w_head]  = out_r_data;
      in_r_valid[w_head] = out_r_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!w_clr && w_hs) r_fifo[r_wptr] <= w_sel;
  end

  always_ff @(posedge clk_i) begin
    if (w_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_hs)    r_wptr <= f_inc(r_wptr);
      if (w_pop)   r_rptr <= f_inc(r_rptr);
      if (w_unexp) r_err  <= 1'b1;
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign outstanding_o = r_count;
  assign err_o         = r_err;

endmodule

// File: tb/tb_fir_tcdm_arbiter.sv
// Directed plus random bench for fir_tcdm_arbiter; a queue-based model predicts every output each cycle.
module tb_fir_tcdm_arbiter;

  localparam int NR      = 3;
  localparam int DW      = 32;
  localparam int MAX_OUT = 2;

  logic                   clk = 1'b0;
  logic                   rst_i, clear_i;
  logic [NR-1:0]          in_req, in_gnt, in_wen, in_r_valid;
  logic [NR-1:0][31:0]    in_add;
  logic [NR-1:0][DW/8-1:0] in_be;
  logic [NR-1:0][DW-1:0]  in_data, in_r_data;
  logic                   out_req, out_wen, out_gnt, out_r_valid, err_o;
  logic [31:0]            out_add;
  logic [DW/8-1:0]        out_be;
  logic [DW-1:0]          out_data, out_r_data;
  logic [1:0]             outstanding_o;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         last_g   = NR - 1;
  logic [1:0] exp_q[$];
  logic       m_err    = 1'b0;
  int         g_idx    = -1;
  int         exp_order[6];

  always #5 clk = ~clk;

  fir_tcdm_arbiter #(.NR(NR), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
    .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
    .out_req(out_req), .out_add(out_add), .out_wen(out_wen), .out_be(out_be),
    .out_data(out_data), .out_gnt(out_gnt), .out_r_data(out_r_data),
    .out_r_valid(out_r_valid), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_payload();
    for (int r = 0; r < NR; r++) begin
      in_add[r]  = $urandom;
      in_data[r] = $urandom;
      in_be[r]   = 4'($urandom_range(0, 15));
      in_wen[r]  = 1'($urandom_range(0, 1));
    end
    out_r_data = $urandom;
  endtask

  // One clock: randomise payload, check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    int                     cnt, sel, c;
    logic                   e_req;
    logic [NR-1:0]          e_gnt, e_rv;
    logic [NR-1:0][DW-1:0]  e_rd;
    rand_payload();
    @(negedge clk);
    cnt = (rst_i || clear_i) ? 0 : exp_q.size();
    sel = -1;
    for (int k = 1; k <= NR; k++) begin
`ifdef FIR_TCDM_ARB_FIXED_PRIO_EN
      c = k - 1;
`else
      c = (last_g + k) % NR;
`endif
      if (sel < 0 && in_req[c]) sel = c;
    end
    e_req = (sel >= 0) && (cnt < MAX_OUT);
    e_gnt = '0;
    if (e_req && out_gnt) e_gnt[sel] = 1'b1;
    e_rv = '0;
    e_rd = '0;
    if (cnt > 0) begin
      e_rd[exp_q[0]] = out_r_data;
      e_rv[exp_q[0]] = out_r_valid;
    end
    check("out_req", out_req, e_req);
    check("in_gnt", in_gnt, e_gnt);
    check("out_add", out_add, e_req ? in_add[sel] : 32'h0);
    check("out_data", out_data, e_req ? in_data[sel] : 32'h0);
    check("out_be", out_be, e_req ? in_be[sel] : 4'h0);
    check("out_wen", out_wen, e_req ? in_wen[sel] : 1'b0);
    check("in_r_valid", in_r_valid, e_rv);
    check("in_r_data", in_r_data, e_rd);
    check("outstanding", outstanding_o, exp_q.size());
    check("err", err_o, m_err);
    g_idx = -1;
    for (int k = NR - 1; k >= 0; k--) if (in_gnt[k]) g_idx = k;
    @(posedge clk);
    if (rst_i || clear_i) begin
      exp_q.delete();
      last_g = NR - 1;
      m_err  = 1'b0;
    end else begin
      if (out_r_valid) begin
        if (cnt > 0) void'(exp_q.pop_front());
        else m_err = 1'b1;
      end
      if (e_req && out_gnt) begin
        exp_q.push_back(2'(sel));
        last_g = sel;
      end
    end
    #1;
  endtask

  task automatic drain();
    in_req = '0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      out_r_valid = 1'b1;
      cycle();
    end
    out_r_valid = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; in_req = '0; out_gnt = 1'b0; out_r_valid = 1'b0;
    rand_payload();
    cycle();
    cycle();
    rst_i = 1'b0;

    // Round-robin order with one-cycle responses.
`ifdef FIR_TCDM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 0, 1, 2};
`endif
    in_req = 3'b111; out_gnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      out_r_valid = (exp_q.size() > 0);
      cycle();
      check("grant_order", g_idx, exp_order[i]);
    end
    drain();

    // Fill to MAX_OUT with responses withheld.
    in_req = 3'b111; out_gnt = 1'b1; out_r_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("full_outstanding", outstanding_o, 2);
    check("full_out_req", out_req, 0);
    out_r_valid = 1'b1;
    cycle();
    out_r_valid = 1'b0;
    check("after_pop_outstanding", outstanding_o, 1);
    check("after_pop_out_req", out_req, 1);
    cycle();
    drain();

    // Waiting request keeps its selection while the port stalls.
    rst_i = 1'b1; cycle(); rst_i = 1'b0;
    in_req = 3'b001; out_gnt = 1'b1; cycle();
    drain();
    in_req = 3'b010; out_gnt = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    in_req = 3'b011;
    cycle();
`ifndef FIR_TCDM_ARB_FIXED_PRIO_EN
    check("stall_sel_add", out_add, in_add[1]);
`endif
    out_gnt = 1'b1;
    cycle();
`ifdef FIR_TCDM_ARB_FIXED_PRIO_EN
    check("stall_grant", g_idx, 0);
`else
    check("stall_grant", g_idx, 1);
`endif
    out_r_valid = 1'b1;
    cycle();
    check("next_grant", g_idx, 0);
    out_r_valid = 1'b0;
    drain();

    // Unexpected response sets a sticky error; clear removes it.
    in_req = '0; out_r_valid = 1'b1; cycle();
    out_r_valid = 1'b0; cycle();
    check("err_set", err_o, 1);
    cycle();
    check("err_held", err_o, 1);
    clear_i = 1'b1; cycle(); clear_i = 1'b0;
    check("err_cleared", err_o, 0);

    // Reset with two outstanding discards routing and restores priority to 0.
    in_req = 3'b111; out_gnt = 1'b1; out_r_valid = 1'b0;
    cycle(); cycle();
    check("pre_rst_outstanding", outstanding_o, 2);
    rst_i = 1'b1; cycle(); rst_i = 1'b0;
    check("post_rst_outstanding", outstanding_o, 0);
    cycle();
    check("post_rst_grant", g_idx, 0);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_req      = 3'($urandom_range(0, 7));
      out_gnt     = ($urandom_range(0, 3) != 0);
      out_r_valid = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 49) == 0);
      clear_i     = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tcdm_arbiter.md
FIR_TCDM_ARBITER -- requirements
Module: fir_tcdm_arbiter

Interface
REQ-001 Parameter NR, default 3: number of requesters (x, h, y streamers), range 2..8.
REQ-002 Parameter DW, default 32: data width; byte-enable width is DW/8.
REQ-003 Parameter MAX_OUT, default 2: maximum outstanding transactions, range 1..8.
REQ-004 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 Port clear_i, input, 1: synchronous soft clear, same effect as rst_i.
REQ-007 Ports in_req/in_gnt, input/output, [NR]: per-requester request/grant.
REQ-008 Ports in_add [NR][32], in_wen [NR] (1 = read), in_be [NR][DW/8], in_data [NR][DW]: inputs, per-requester request payload.
REQ-009 Ports in_r_data [NR][DW] and in_r_valid [NR]: outputs, per-requester response.
REQ-010 Ports out_req, out_add, out_wen, out_be, out_data: outputs, single shared TCDM master request.
REQ-011 Ports out_gnt, out_r_data, out_r_valid: inputs, shared TCDM grant and response.
REQ-012 Port outstanding_o, output, $clog2(MAX_OUT+1): current outstanding count.
REQ-013 Port err_o, output, 1: sticky error flag for an unexpected response.

Function
REQ-014 Shared port: one response per granted request (read or write), in order, at least 1 cycle after grant.
REQ-015 Arbitration: round-robin; search starts at last granted index + 1, modulo NR.
REQ-016 Selected index sel is combinational from in_req and the RR pointer; no request-to-out_req register stage (0-cycle latency).
REQ-017 out_req = (|in_req) & !full; out_add/wen/be/data = payload of requester sel; payload is 0 when out_req=0.
REQ-018 in_gnt[sel] = out_gnt & out_req; all other in_gnt = 0.
REQ-019 RR pointer updates to sel only on a handshake (out_req & out_gnt); a waiting request keeps its selection.
REQ-020 Route FIFO depth MAX_OUT: pushes sel on handshake; pops on out_r_valid.
REQ-021 The FIFO head index routes out_r_data to in_r_data[head] with in_r_valid[head]=out_r_valid in the same cycle (combinational).
REQ-022 Non-head in_r_data are 0.
REQ-023 full = (count == MAX_OUT).
REQ-024 When full and out_r_valid in the same cycle, out_req remains 0 (no bypass); the pop completes.
REQ-025 Simultaneous push and pop when not full: count unchanged, order preserved.
REQ-026 outstanding_o = count; pointers wrap modulo MAX_OUT.
REQ-027 Unexpected response (out_r_valid with count==0): all in_r_valid=0, FIFO unchanged, err_o set until reset or clear.

Reset
REQ-028 On rst_i or clear_i: RR pointer=NR-1 (requester 0 has first priority); FIFO empty; outstanding_o=0; err_o=0.
REQ-029 Reset or clear mid-operation discards in-flight routing entries; responses arriving afterwards are treated per REQ-027.
REQ-030 During a reset cycle all combinational outputs still follow REQ-017/018 with count=0.

Configuration
REQ-031 Macro FIR_TCDM_ARB_FIXED_PRIO_EN is the only configuration option.
REQ-032 With FIR_TCDM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, and the RR pointer is not implemented.
REQ-033 Without FIR_TCDM_ARB_FIXED_PRIO_EN: round-robin per REQ-015.

Verification
REQ-034 NR=3, all in_req=1, out_gnt=1 always, responses 1 cycle later -> grant order 0,1,2,0,1,2; each in_r_valid lands on the issuing requester.
REQ-035 MAX_OUT=2, out_gnt=1, responses withheld -> after 2 handshakes out_req=0 and outstanding_o=2; first response -> outstanding_o=1, and out_req=1 in the next cycle.
REQ-036 in_req[1]=1, out_gnt=0 for 3 cycles, then in_req[0] rises -> sel stays 1 until granted; then requester 0 is served.
REQ-037 out_r_valid pulsed with count=0 -> no in_r_valid; err_o=1 and held; clear_i=1 -> err_o=0.
REQ-038 rst_i asserted with 2 outstanding -> outstanding_o=0 next cycle; next grant goes to requester 0.
REQ-039 Build with FIR_TCDM_ARB_FIXED_PRIO_EN, all in_req=1 -> requester 0 granted every cycle; requesters 1 and 2 starve.
